// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage.
//
// Holds the program counter, drives the instruction ROM word address and
// captures the combinational ROM word into a 2-entry buffer that is drained
// by decode through a valid/ready handshake. Unconditional jumps are
// resolved here, so no bubble is taken across them. Taken branches arrive
// from execute as a one-cycle redirect pulse that flushes the buffer.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   rom_addr_o        ROM word address (always the fetch PC)
//   rom_inst_i        ROM data, combinational from rom_addr_o
//   out_valid_o       head entry present and not being killed
//   out_ready_i       decode accepts the head entry
//   out_inst_o        head entry instruction (0 when empty)
//   out_pc_o          head entry PC (0 when empty)
//   redirect_valid_i  redirect pulse from execute
//   redirect_pc_i     redirect target
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_inst_o,
    output logic [ADDR_W-1:0] out_pc_o,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    localparam logic [5:0]        OP_JUMP = 6'b010010;
    localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q   [2];
    logic [ADDR_W-1:0] pc_d   [2];
    logic [DATA_W-1:0] inst_q [2];
    logic [DATA_W-1:0] inst_d [2];
    logic [1:0]        count_q, count_d;

    logic              pop, enq, is_jump;
    logic [ADDR_W-1:0] next_pc;

    // Slot 0 is always the head; slot 1 shifts down on a pop.
    assign rom_addr_o  = fetch_pc_q;
    assign out_valid_o = (count_q != 2'd0) & ~redirect_valid_i;
    assign out_inst_o  = (count_q != 2'd0) ? inst_q[0] : '0;
    assign out_pc_o    = (count_q != 2'd0) ? pc_q[0]   : '0;

    assign pop     = out_valid_o & out_ready_i;
    assign enq     = ~redirect_valid_i & ((count_q != 2'd2) | pop);
    assign is_jump = (rom_inst_i[31:26] == OP_JUMP);
    // Jump target is taken from the low address bits; upper target bits ignored.
    assign next_pc = is_jump ? rom_inst_i[ADDR_W-1:0] : fetch_pc_q + ADDR_W'(1);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        pc_d       = pc_q;
        inst_d     = inst_q;

        if (redirect_valid_i) begin
            // Flush; any pop in this cycle is discarded along with the entries.
            count_d    = 2'd0;
            fetch_pc_d = redirect_pc_i;
        end else begin
            if (enq) begin
                fetch_pc_d = next_pc;
            end
            case ({enq, pop})
                2'b10: begin
                    // Not full here, so count is 0 or 1 and picks the free slot.
                    pc_d[count_q[0]]   = fetch_pc_q;
                    inst_d[count_q[0]] = rom_inst_i;
                    count_d            = count_q + 2'd1;
                end
                2'b01: begin
                    pc_d[0]   = pc_q[1];
                    inst_d[0] = inst_q[1];
                    count_d   = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        pc_d[0]   = pc_q[1];
                        inst_d[0] = inst_q[1];
                        pc_d[1]   = fetch_pc_q;
                        inst_d[1] = rom_inst_i;
                    end else begin
                        pc_d[0]   = fetch_pc_q;
                        inst_d[0] = rom_inst_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= PC_RST;
            count_q    <= 2'd0;
            pc_q[0]    <= '0;
            pc_q[1]    <= '0;
            inst_q[0]  <= '0;
            inst_q[1]  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- directed bench for inst_fetch with a behavioural ROM.
// A per-cycle vector table covers streaming, stall, redirect, wrap-around
// and reset; hand-written sequences cover jumps and redirect-vs-jump.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [5:0]  out_pc;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;

    logic [31:0] rom [64];
    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    inst_fetch #(.ADDR_W(6), .DATA_W(32), .RESET_PC(0)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .rom_addr_o       (rom_addr),
        .rom_inst_i       (rom_inst),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_inst_o       (out_inst),
        .out_pc_o         (out_pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc)
    );

    localparam logic [31:0] JUMP_TO_1 = 32'h4800_0001;

    int total = 0;
    int bad   = 0;

    // Plain program: distinct non-jump words, nops at 62/63.
    function automatic logic [31:0] romw(input logic [5:0] a);
        if (a >= 6'd62) return 32'h0;
        return 32'h0400_0000 | {26'h0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst, rdy, rv;
        logic [5:0] rpc;
        logic       ev, ee;     // expected valid, expected buffer empty
        logic [5:0] epc, eaddr;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic v, input logic [5:0] p,
                                input logic ev, input logic ee, input logic [5:0] epc,
                                input logic [5:0] ea);
        vec_t t;
        t.rst = r; t.rdy = rd; t.rv = v; t.rpc = p;
        t.ev = ev; t.ee = ee; t.epc = epc; t.eaddr = ea;
        return t;
    endfunction

    initial begin
        int  exp_pc   [9] = '{0, 1, 2, 3, 4, 5, 1, 2, 3};
        int  exp_addr [9] = '{1, 2, 3, 4, 5, 1, 2, 3, 4};
        bit  found;
        logic [31:0] ei;

        for (int a = 0; a < 64; a++) rom[a] = romw(6'(a));
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        //        rst rdy rv rpc   ev ee epc addr
        tv.push_back(mk(1, 0, 0, 0,    0, 1, 0,  0));  // reset state
        tv.push_back(mk(0, 1, 0, 0,    0, 1, 0,  0));  // first cycle after release
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 0,  1));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 1,  2));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 2,  3));
        tv.push_back(mk(0, 0, 0, 0,    1, 0, 3,  4));  // stall begins
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0, 0, 0, 0, 1, 0, 3,  5)); // full, address held
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 3,  5));  // full + pop + enq
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 4,  6));
        tv.push_back(mk(0, 0, 0, 0,    1, 0, 5,  7));  // full again
        tv.push_back(mk(0, 0, 1, 7,    0, 0, 5,  7));  // redirect while full
        tv.push_back(mk(0, 1, 0, 0,    0, 1, 0,  7));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 7,  8));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 8,  9));
        tv.push_back(mk(0, 1, 1, 62,   0, 0, 9, 10));  // redirect to 62
        tv.push_back(mk(0, 1, 0, 0,    0, 1, 0, 62));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 62, 63));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 63, 0)); // wrap
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 0,  1));
        tv.push_back(mk(0, 0, 0, 0,    1, 0, 1,  2));
        tv.push_back(mk(1, 0, 1, 30,   0, 0, 1,  3));  // rst + redirect while full
        tv.push_back(mk(0, 1, 0, 0,    0, 1, 0,  0));
        tv.push_back(mk(0, 1, 0, 0,    1, 0, 0,  1));

        repeat (2) @(posedge clk);

        foreach (tv[i]) begin
            @(posedge clk); #1;
            rst = tv[i].rst; out_ready = tv[i].rdy;
            redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
            @(negedge clk);
            ei = tv[i].ee ? 32'h0 : romw(tv[i].epc);
            chk($sformatf("v%0d.valid", i), {31'h0, out_valid}, {31'h0, tv[i].ev});
            chk($sformatf("v%0d.pc", i),    {26'h0, out_pc},    {26'h0, tv[i].epc});
            chk($sformatf("v%0d.inst", i),  out_inst,           ei);
            chk($sformatf("v%0d.addr", i),  {26'h0, rom_addr},  {26'h0, tv[i].eaddr});
        end

        // Jump at 5 -> 1: continuous stream with no bubble.
        rom[5] = JUMP_TO_1;
        @(posedge clk); #1; rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("jmp.start_valid", {31'h0, out_valid}, 32'h0);
        chk("jmp.start_addr",  {26'h0, rom_addr},  32'h0);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); @(negedge clk);
            ei = (exp_pc[i] == 5) ? JUMP_TO_1 : romw(6'(exp_pc[i]));
            chk($sformatf("jmp%0d.valid", i), {31'h0, out_valid}, 32'h1);
            chk($sformatf("jmp%0d.pc", i),    {26'h0, out_pc},    32'(exp_pc[i]));
            chk($sformatf("jmp%0d.inst", i),  out_inst,           ei);
            chk($sformatf("jmp%0d.addr", i),  {26'h0, rom_addr},  32'(exp_addr[i]));
        end

        // Redirect in the same cycle the jump word is being fetched.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rom_addr == 6'd5) found = 1'b1;
            else @(posedge clk);
        end
        chk("rj.reach_addr5", {31'h0, found}, 32'h1);
        redirect_valid = 1'b1; redirect_pc = 6'd40;
        #1;
        chk("rj.masked_valid", {31'h0, out_valid}, 32'h0);
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        chk("rj.addr_next", {26'h0, rom_addr},  32'd40);
        chk("rj.valid_n1",  {31'h0, out_valid}, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("rj.valid_n2", {31'h0, out_valid}, 32'h1);
        chk("rj.pc_n2",    {26'h0, out_pc},    32'd40);
        chk("rj.inst_n2",  out_inst,           romw(6'd40));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream-facing to decode. Holds the program counter and drives the ROM word address. Captures the combinational ROM output into a 2-entry instruction buffer with a valid/ready handshake to decode. Resolves unconditional `jump` locally and accepts redirects (taken `beq`) from execute.

## Interface
- `ADDR_W`, 6: PC / ROM word-address width; 64-word program space.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rom_addr`  out  ADDR_W  word address to ROM; always equals `fetch_pc`.
- `rom_inst`  in  DATA_W  ROM data; combinational from `rom_addr`, same cycle.
- `out_valid`  out  1  head buffer entry present and not being killed.
- `out_ready`  in  1  decode accepts head entry.
- `out_inst`  out  DATA_W  head entry instruction; 0 when buffer empty.
- `out_pc`  out  ADDR_W  head entry PC; 0 when buffer empty.
- `redirect_valid`  in  1  execute redirect (taken branch), one-cycle pulse.
- `redirect_pc`  in  ADDR_W  redirect target.

## Operation
- State: `fetch_pc` (ADDR_W), 2-entry FIFO of {pc, inst}, `count` (0..2).
- Instruction fields: op = [31:26]; jump op = 6'b010010, target = [ADDR_W-1:0] (upper target bits ignored).
- `pop` = `out_valid & out_ready`.
- `enq` = `~redirect_valid & (count < 2 | pop)`.
- Each cycle, by priority:
  - `redirect_valid`: FIFO flushed (`count` <= 0), `fetch_pc` <= `redirect_pc`, no enqueue, the pop is ignored.
  - else if `enq`: push {`fetch_pc`, `rom_inst`}; `fetch_pc` <= jump target if `rom_inst` op is jump, else `fetch_pc + 1` mod 2^ADDR_W (63 wraps to 0).
  - else (full, no pop): `fetch_pc` and FIFO held; ROM re-read at the same address.
- The jump instruction itself is still forwarded to decode; decode/execute must not redirect on it.
- All-zero words (nop) are fetched and forwarded like any other instruction.
- `count` update: +1 on enq only, -1 on pop only, unchanged on both or neither.
- `out_valid` = (`count` != 0) & ~`redirect_valid`: the head entry is masked in the redirect cycle.

## Timing
- Reset values: `fetch_pc` = RESET_PC, `count` = 0, `out_valid` = 0, `out_inst` = 0, `out_pc` = 0, `rom_addr` = RESET_PC.
- Reset asserted mid-operation overrides redirect, enqueue and pop. The state is reset at the next edge, and buffered entries are discarded.
- Fetch-to-decode latency is 1 cycle, with no bypass. An entry pushed at edge N is presented with `out_valid` = 1 in cycle N+1.
- First cycle after `rst` deasserts: `rom_addr` = RESET_PC, `out_valid` = 0. Next cycle: `out_valid` = 1, `out_pc` = RESET_PC.
- Sustained throughput is 1 instruction/cycle while `out_ready` = 1, including across jumps (no bubble).
- Full with simultaneous pop: enqueue and pop occur in the same cycle; `count` stays 2.
- Redirect asserted in cycle N:
  - cycle N: `out_valid` = 0.
  - cycle N+1: buffer empty, `rom_addr` = `redirect_pc`.
  - cycle N+2: `out_valid` = 1 with `out_pc` = `redirect_pc`.
- Redirect and a fetched jump in the same cycle: the redirect wins and the jump is discarded.
- Handshake: `out_inst` and `out_pc` stay stable while `out_valid` = 1 and `out_ready` = 0, unless a redirect occurs.

## Test plan
- Reset, `out_ready` = 1, ROM words 0..7 distinct. Required: `out_pc` = 0,1,2,3,… on consecutive cycles starting 2 cycles after reset release, with `out_inst` matching the ROM word at each address.
- Jump at addr 5 (target 1). Required: `out_pc` = 3,4,5,1,2,3 with no gap; `rom_addr` goes 5→1.
- `out_ready` = 0 for 6 cycles after streaming starts. Required: `count` saturates at 2 and `rom_addr` holds. On release, the `out_pc` sequence continues with no loss or duplicate.
- Buffer full, `redirect_valid` pulse with `redirect_pc` = 7. Required: `out_valid` = 0 for 2 cycles, then `out_pc` = 7,8,…; the flushed entries never appear.
- Redirect to 62 with nop words. Required: `out_pc` = 62,63,0,1 (wrap-around).
- `rst` pulsed while full and mid-stream. Required: next cycle `out_valid` = 0 and `rom_addr` = 0. Also, a redirect together with a fetched jump in the same cycle: `rom_addr` next = `redirect_pc`.
